sram_rw_ctrl: RTL and testbench
===============================

Name: sram_rw_ctrl

Overview:
- Initiator-side controller for a single-port, 1-cycle-read-latency SRAM macro: 64 entries × 24 bits, one RW port with addr/en/wmode/wmask/wdata/rdata.
- Sits between a valid/ready request/response client and the macro's RW port.
- After reset it sweeps the whole array to zero.
- It then serialises client reads and writes onto the port, captures read data and buffers it under response backpressure.

Parameters:
- DEPTH, 64, number of SRAM entries.
- ADDR_W, 6, address width, log2(DEPTH).
- DATA_W, 24, data width; one mask bit covers the full word.
- RESP_DEPTH, 4, response buffer entries; also the maximum number of outstanding reads.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  client consumes response.
- resp_rdata  out  DATA_W  read data, in request order.
- init_done  out  1  zero-sweep complete.
- sram_addr  out  ADDR_W  to macro RW0_addr.
- sram_en  out  1  to macro RW0_en.
- sram_wmode  out  1  to macro RW0_wmode.
- sram_wmask  out  1  to macro RW0_wmask.
- sram_wdata  out  DATA_W  to macro RW0_wdata.
- sram_rdata  in  DATA_W  from macro RW0_rdata; valid the cycle after a read command.

Behaviour:
- Reset values (asynchronous): state=INIT, init counter=0, init_done=0, req_ready=0, resp_valid=0, outstanding=0, response buffer empty.
- Reset values of the SRAM command registers: sram_en=0, sram_wmode=0, sram_wmask=0, sram_addr=0, sram_wdata=0.
- All sram_* outputs are registered; the command register is loaded on the edge a command is issued, and the macro executes it on the following edge.
- State INIT:
  - Each edge loads a write command: addr=counter, wdata=0, wmask=1, wmode=1, en=1.
  - The counter increments each edge.
  - On the edge that loads addr DEPTH-1, state→RUN.
  - init_done=1 from that point; it holds until reset.
  - No client request is accepted in INIT.
- State RUN, acceptance:
  - req_ready = (outstanding < RESP_DEPTH).
  - outstanding counts reads accepted but not yet consumed by a resp_valid && resp_ready handshake.
  - The same ready applies to reads and writes, so ready never depends on req_write.
- State RUN, command issue:
  - On accept, the command register loads {en=1, wmode=req_write, wmask=1, addr, wdata}.
  - With no accept, en=0 and the other fields hold their values.
- Read pipeline:
  - Accept at edge T; the command is visible at T+1; the macro registers the address at edge T+1.
  - sram_rdata is sampled at edge T+2 into the response buffer.
  - resp_valid is first high in the cycle after edge T+2, i.e. 3-cycle accept-to-response latency.
  - Empty-buffer case: resp_rdata is the buffer head, with no combinational bypass.
- Throughput: one accepted request per cycle while credits remain.
- outstanding update: +1 on read accept, −1 on response handshake; both in the same cycle leave it unchanged.
- Ordering: every command goes through one command register in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Response buffer:
  - FIFO of RESP_DEPTH entries; cannot overflow because of the credit limit.
  - Enqueue and dequeue in the same cycle on a full buffer is legal.
- Reset mid-operation:
  - All state clears immediately, including in-flight reads and buffered responses; they are dropped without a response.
  - The zero sweep restarts from address 0 after release.
- Address wrap: no wrap logic; addresses are used as given. The init counter stops at DEPTH-1.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - DEPTH, ADDR_W, DATA_W, RESP_DEPTH defaults;
  - state encoding INIT=0, RUN=1;
  - sram_cmd_t struct {en, wmode, wmask, addr, wdata}.
- One sub-module, sram_resp_fifo: synchronous FIFO, RESP_DEPTH × DATA_W, asynchronous active-high reset, enq/deq with full/empty flags.

Test Plan:
- Release reset, hold req_valid=1 → sram_en=1, wmode=1, wdata=0 at addresses 0..63 in consecutive cycles; req_ready and init_done rise together exactly 64 cycles after release; no accept before that.
- After init, read addr 5 with no prior write → resp_valid 3 cycles after accept with rdata=0x000000; exactly one response.
- Write addr 63 = 0xABCDEF, then read addr 63 the next cycle → response 0xABCDEF; command order on sram_* is write then read.
- resp_ready=0 with 6 back-to-back reads offered → exactly 4 accepted, then req_ready=0. Raise resp_ready → 4 responses in order; req_ready returns the cycle after the first handshake.
- Assert reset while 2 reads are outstanding and 1 response is buffered → resp_valid=0 and sram_en=0 immediately; after release a full 64-write sweep repeats and no stale response appears.
- Streaming writes to addrs 0..63 with data = addr×0x010101, then reads 0..63 with resp_ready=1 → 64 in-order matching responses; req_ready stays 1 throughout, since 4 credits cover the 3-cycle latency.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM read/write controller slice.
package sram_ctrl_pkg;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned RESP_DEPTH = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic              en;
    logic              wmode;
    logic              wmask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response buffer: small synchronous FIFO with full/empty flags.
// The caller guarantees no enqueue into a full FIFO without a dequeue,
// and no dequeue from an empty FIFO.
module sram_resp_fifo #(
  parameter int unsigned DEPTH  = sram_ctrl_pkg::RESP_DEPTH,
  parameter int unsigned DATA_W = sram_ctrl_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic [DATA_W-1:0] deq_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign deq_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // Storage, pointers and occupancy; simultaneous enq/deq keeps count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rw_ctrl.sv
// Initiator-side controller for a 1-cycle-latency single-port SRAM:
// zero-sweeps the array after reset, then serialises client requests
// onto the RW port and buffers read data under response backpressure.
module sram_rw_ctrl #(
  parameter int unsigned DEPTH      = sram_ctrl_pkg::DEPTH,
  parameter int unsigned ADDR_W     = sram_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W     = sram_ctrl_pkg::DATA_W,
  parameter int unsigned RESP_DEPTH = sram_ctrl_pkg::RESP_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  import sram_ctrl_pkg::*;

  localparam int unsigned OUT_W = $clog2(RESP_DEPTH + 1);

  ctrl_state_t      state;
  logic [ADDR_W-1:0] init_cnt;
  sram_cmd_t        cmd;
  logic [OUT_W-1:0] outstanding;
  logic             rd_capture;
  logic             accept;
  logic             read_accept;
  logic             resp_fire;
  logic             fifo_enq;
  logic             fifo_full;
  logic             fifo_empty;

  // Credits count reads from accept until their response handshake, so the
  // buffer can never be asked to hold more than RESP_DEPTH entries.
  assign req_ready   = (state == RUN) && (outstanding < OUT_W'(RESP_DEPTH));
  assign accept      = req_valid && req_ready;
  assign read_accept = accept && !req_write;
  assign resp_valid  = !fifo_empty;
  assign resp_fire   = resp_valid && resp_ready;
  assign fifo_enq    = rd_capture && (!fifo_full || resp_fire);

  assign sram_en    = cmd.en;
  assign sram_wmode = cmd.wmode;
  assign sram_wmask = cmd.wmask;
  assign sram_addr  = cmd.addr;
  assign sram_wdata = cmd.wdata;

  // Sweep/run FSM driving the registered SRAM command
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      cmd       <= '0;
    end else begin
      case (state)
        INIT: begin
          cmd <= '{en: 1'b1, wmode: 1'b1, wmask: 1'b1, addr: init_cnt, wdata: '0};
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (accept) begin
            cmd <= '{en: 1'b1, wmode: req_write, wmask: 1'b1, addr: req_addr, wdata: req_wdata};
          end else begin
            cmd.en <= 1'b0;
          end
        end
      endcase
    end
  end

  // Outstanding-read credit counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({read_accept, resp_fire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Marks the cycle in which the macro presents data for the read it just executed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_capture <= 1'b0;
    end else begin
      rd_capture <= cmd.en && !cmd.wmode;
    end
  end

  sram_resp_fifo #(
    .DEPTH  (RESP_DEPTH),
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock    (clock),
    .reset    (reset),
    .enq      (fifo_enq),
    .enq_data (sram_rdata),
    .deq      (resp_fire),
    .deq_data (resp_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Bench for sram_rw_ctrl: behavioural SRAM macro, transaction-level model
// of the controller, per-cycle comparison plus directed literal checks.
module tb_sram_rw_ctrl;

  localparam int AW = 6;
  localparam int DW = 24;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic          sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  sram_rw_ctrl #(
    .DEPTH      (64),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RESP_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural SRAM macro; contents start random and survive reset
  logic [DW-1:0] macro_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) macro_mem[i] = DW'($urandom);
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        if (sram_wmask) macro_mem[sram_addr] <= sram_wdata;
      end else begin
        sram_rdata <= macro_mem[sram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Transaction-level model: edges since reset release, array contents as
  // seen in acceptance order, and pending read results with visibility time.
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [64];
  int            edges = 0;
  logic          exp_en = 1'b0;
  logic          exp_wmode = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      edges  = 0;
      q.delete();
      exp_en = 1'b0;
    end else begin
      logic m_ready, acc, pop;
      m_ready = (edges >= 64) && (q.size() < 4);
      acc     = m_ready && req_valid;
      pop     = (q.size() > 0) && (q[0].due <= edges) && resp_ready;
      if (edges < 64) begin
        exp_en = 1'b1; exp_wmode = 1'b1; exp_addr = AW'(edges); exp_wdata = '0;
        ref_mem[edges] = '0;
      end else if (acc) begin
        exp_en = 1'b1; exp_wmode = req_write; exp_addr = req_addr; exp_wdata = req_wdata;
        if (req_write) ref_mem[req_addr] = req_wdata;
        else q.push_back('{data: ref_mem[req_addr], due: edges + 3});
      end else begin
        exp_en = 1'b0;
      end
      if (pop) void'(q.pop_front());
      edges++;
    end
  end

  // Per-cycle comparison against the model, plus response logging
  logic [DW-1:0] got_data[$];
  int            got_edge[$];

  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      logic exp_rv;
      exp_rv = (q.size() > 0) && (q[0].due <= edges);
      chk("init_done", init_done, (edges >= 64));
      chk("req_ready", req_ready, (edges >= 64) && (q.size() < 4));
      chk("resp_valid", resp_valid, exp_rv);
      chk("sram_en", sram_en, exp_en);
      if (exp_en) begin
        chk("sram_wmode", sram_wmode, exp_wmode);
        chk("sram_wmask", sram_wmask, 1);
        chk("sram_addr", sram_addr, exp_addr);
        chk("sram_wdata", sram_wdata, exp_wdata);
      end
      if (exp_rv) chk("resp_rdata", resp_rdata, q[0].data);
      if (resp_valid && resp_ready) begin
        got_data.push_back(resp_rdata);
        got_edge.push_back(edges + 1);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waited);
    waited = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    chk("send_ready_seen", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_resps(input int cnt);
    int n = 0;
    while (got_data.size() < cnt && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, acc, stall, t_acc;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_sram_en", sram_en, 0);

    // Sweep with a request held pending the whole time
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd9;
    reset = 1'b0;
    wait_init(n);
    req_valid = 1'b0;
    chk("init_ready_rise_cycles", n, 64);
    chk("init_done_at_ready", init_done, 1);

    // Read of a never-written address returns the swept zero
    @(negedge clock);
    got_data.delete(); got_edge.delete();
    send(1'b0, 6'd5, '0, st);
    t_acc = edges;
    wait_resps(1);
    repeat (5) @(negedge clock);
    chk("rd5_count", got_data.size(), 1);
    if (got_data.size() > 0) begin
      chk("rd5_data", got_data[0], 0);
      chk("rd5_latency", got_edge[0] - t_acc, 3);
    end

    // Write then read the same address back-to-back
    got_data.delete(); got_edge.delete();
    send(1'b1, 6'd63, 24'hABCDEF, st);
    send(1'b0, 6'd63, '0, st);
    wait_resps(1);
    chk("raw63_data", (got_data.size() > 0) ? got_data[0] : 32'hFFFF_FFFF, 24'hABCDEF);

    // Credit limit under response backpressure
    for (int k = 0; k < 4; k++) send(1'b1, AW'(20 + k), DW'((k + 1) * 32'h111111), st);
    repeat (2) @(negedge clock);
    got_data.delete(); got_edge.delete();
    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(20 + k);
      if (!req_ready) break;
      @(negedge clock);
      acc++;
    end
    repeat (3) @(negedge clock);
    chk("bp_ready_low", req_ready, 0);
    req_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    resp_ready = 1'b1;
    wait_resps(4);
    repeat (3) @(negedge clock);
    chk("bp_resp_count", got_data.size(), 4);
    for (int k = 0; k < 4 && k < got_data.size(); k++)
      chk("bp_resp_data", got_data[k], (k + 1) * 32'h111111);

    // Reset with reads in flight and one response buffered
    resp_ready = 1'b0;
    send(1'b0, 6'd30, '0, st);
    send(1'b0, 6'd31, '0, st);
    send(1'b0, 6'd32, '0, st);
    chk("rst_pre_resp_valid", resp_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (3) @(negedge clock);
    got_data.delete(); got_edge.delete();
    resp_ready = 1'b1;
    reset = 1'b0;
    wait_init(n);
    chk("resweep_ready_rise_cycles", n, 64);
    repeat (6) @(negedge clock);
    chk("no_stale_resp", got_data.size(), 0);

    // Streaming writes then streaming reads at full rate
    stall = 0;
    for (int a = 0; a < 64; a++) begin
      send(1'b1, AW'(a), DW'(a * 32'h010101), st);
      stall += st;
    end
    got_data.delete(); got_edge.delete();
    for (int a = 0; a < 64; a++) begin
      send(1'b0, AW'(a), '0, st);
      stall += st;
    end
    wait_resps(64);
    chk("stream_stalls", stall, 0);
    chk("stream_resp_count", got_data.size(), 64);
    for (int a = 0; a < 64 && a < got_data.size(); a++)
      chk("stream_resp_data", got_data[a], a * 32'h010101);

    // Random traffic checked by the model only
    for (int i = 0; i < 1500; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom_range(0, 63));
      req_wdata  = DW'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (20) @(negedge clock);
    chk("drain_empty", resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
